icache_fetch_responder: RTL and testbench

- Instruction-side memory responder serving the fetch stage's combinational instruction request (address out, instruction back in the same cycle).
- Direct-mapped instruction cache. A hit returns the instruction combinationally with no stall.
- A miss asserts Stall_2IF and runs a line-fill state machine against a slower backing memory using a req/ack handshake.
- Sits between the fetch stage and the instruction-memory/bus model.

---
 rtl/icache_fetch_responder.sv | 114 +++++++++++
 tb/tb_icache_fetch_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache answering the fetch stage combinationally;
// misses stall fetch while a line is filled over a req/ack backing-memory port.
module icache_fetch_responder #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  parameter int OFF_BITS   = $clog2(LINE_WORDS) + 2,
  parameter int IDX_BITS   = $clog2(NUM_LINES)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Addr_fIF,
  output logic [31:0] Instr_2IF,
  output logic        Stall_2IF,
  input  logic        Flush,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Data
);

  localparam int WORD_BITS = OFF_BITS - 2;
  localparam int TAG_BITS  = 32 - OFF_BITS - IDX_BITS;
  localparam int LINE_BITS = 32 - OFF_BITS;
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t                 state, state_nxt;
  logic [WORD_BITS-1:0]   beat;
  logic [LINE_BITS-1:0]   fill_line;
  logic                   flush_pending;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_BITS-1:0]    tag_arr  [NUM_LINES];
  logic [31:0]            data_arr [NUM_LINES][LINE_WORDS];

  logic [IDX_BITS-1:0]    idx, fill_idx;
  logic [WORD_BITS-1:0]   word;
  logic [TAG_BITS-1:0]    tag, fill_tag;
  logic                   hit, ack_take, last_ack;
  logic [1:0]             unused_addr_bits;

  assign idx              = Addr_fIF[OFF_BITS+IDX_BITS-1:OFF_BITS];
  assign word             = Addr_fIF[OFF_BITS-1:2];
  assign tag              = Addr_fIF[31:OFF_BITS+IDX_BITS];
  assign unused_addr_bits = Addr_fIF[1:0];
  assign fill_idx         = fill_line[IDX_BITS-1:0];
  assign fill_tag         = fill_line[LINE_BITS-1:IDX_BITS];

  assign hit       = (state == IDLE) && valid[idx] && (tag_arr[idx] == tag);
  assign ack_take  = (state == FILL) && Mem_Req && Mem_Ack;
  assign last_ack  = ack_take && (beat == LAST_BEAT);

  // Outputs are forced while reset is held, independent of array contents.
  assign Instr_2IF = RESET ? data_arr[idx][word] : '0;
  assign Stall_2IF = !hit || !RESET;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!hit) state_nxt = FILL;
      FILL:    if (last_ack) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      beat          <= '0;
      fill_line     <= '0;
      Mem_Req       <= 1'b0;
      Mem_Addr      <= '0;
      flush_pending <= 1'b0;
      valid         <= '0;
    end else begin
      if (Flush) valid <= '0;
      case (state)
        IDLE: begin
          if (!hit) begin
            fill_line <= Addr_fIF[31:OFF_BITS];
            Mem_Addr  <= {Addr_fIF[31:OFF_BITS], {OFF_BITS{1'b0}}};
            Mem_Req   <= 1'b1;
            beat      <= '0;
          end
        end
        FILL: begin
          if (Flush) flush_pending <= 1'b1;
          if (ack_take) begin
            beat <= beat + 1'b1;
            if (last_ack) Mem_Req  <= 1'b0;
            else          Mem_Addr <= Mem_Addr + 32'd4;
          end
        end
        COMMIT: begin
          // Later assignment overrides the global flush clear for the filled line.
          valid[fill_idx] <= !(flush_pending || Flush);
          flush_pending   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (ack_take)         data_arr[fill_idx][beat] <= Mem_Data;
    if (state == COMMIT)  tag_arr[fill_idx]        <= fill_tag;
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder: fills, hits, conflicts, wait states,
// flush during fill and flush in idle, and reset in the middle of a fill.
module tb_icache_fetch_responder;

  localparam int LW = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Addr_fIF;
  logic [31:0] Instr_2IF;
  logic        Stall_2IF;
  logic        Flush;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ack;
  logic [31:0] Mem_Data;

  int          checks = 0;
  int          errors = 0;
  int          waits_cfg = 0;
  int          wait_cnt = 0;
  logic [31:0] dbase_cfg = '0;

  icache_fetch_responder #(.LINE_WORDS(LW), .NUM_LINES(64)) dut (
    .CLK(CLK), .RESET(RESET), .Addr_fIF(Addr_fIF), .Instr_2IF(Instr_2IF),
    .Stall_2IF(Stall_2IF), .Flush(Flush), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
    .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive fetch inputs, then answer the memory port for this cycle.
  task automatic drive(input logic [31:0] a, input logic f);
    Addr_fIF = a;
    Flush    = f;
    #1;
    if (Mem_Req) begin
      if (wait_cnt == waits_cfg) begin
        Mem_Ack  = 1'b1;
        Mem_Data = dbase_cfg + {30'b0, Mem_Addr[3:2]};
        wait_cnt = 0;
      end else begin
        Mem_Ack  = 1'b0;
        wait_cnt++;
      end
    end else begin
      Mem_Ack  = 1'b0;
      Mem_Data = '0;
    end
    #1;
  endtask

  task automatic miss_fill(input logic [31:0] addr, input logic [31:0] dbase, input int waits,
                           input int flush_cyc, input int exp_stalls, input string tag);
    int stalls = 0;
    int beat = 0;
    logic [31:0] base;
    base      = {addr[31:4], 4'b0};
    dbase_cfg = dbase;
    waits_cfg = waits;
    wait_cnt  = 0;
    for (int c = 0; c < 200; c++) begin
      drive(addr, c == flush_cyc);
      if (!Stall_2IF) break;
      stalls++;
      if (c == 0) chk({tag, "_req_on_miss"}, {31'b0, Mem_Req}, 32'd0);
      if (Mem_Req) begin
        chk({tag, "_mem_addr"}, Mem_Addr, base + 32'(beat * 4));
        if (Mem_Ack) beat = (beat + 1) % LW;
      end
      tick();
    end
    Flush = 1'b0;
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, "_instr"}, Instr_2IF, dbase + {30'b0, addr[3:2]});
    chk({tag, "_req_after"}, {31'b0, Mem_Req}, 32'd0);
  endtask

  initial begin
    RESET    = 1'b0;
    Addr_fIF = '0;
    Flush    = 1'b0;
    Mem_Ack  = 1'b0;
    Mem_Data = '0;
    tick();
    tick();
    chk("rst_stall", {31'b0, Stall_2IF}, 32'd1);
    chk("rst_instr", Instr_2IF, 32'd0);
    chk("rst_req", {31'b0, Mem_Req}, 32'd0);
    chk("rst_addr", Mem_Addr, 32'd0);
    RESET = 1'b1;

    // Zero-wait fill, then in-line hits.
    miss_fill(32'hBFC0_0000, 32'h1000_0000, 0, -1, 6, "fill0");
    for (int k = 1; k < LW; k++) begin
      tick();
      drive(32'hBFC0_0000 + 32'(4 * k), 1'b0);
      chk("sweep_stall", {31'b0, Stall_2IF}, 32'd0);
      chk("sweep_instr", Instr_2IF, 32'h1000_0000 + 32'(k));
      chk("sweep_req", {31'b0, Mem_Req}, 32'd0);
      // Stray ack with no request pending must be ignored.
      Mem_Ack  = 1'b1;
      Mem_Data = 32'hDEAD_BEEF;
    end
    tick();
    drive(32'hBFC0_0004, 1'b0);
    chk("stray_ack_stall", {31'b0, Stall_2IF}, 32'd0);
    chk("stray_ack_instr", Instr_2IF, 32'h1000_0001);
    tick();

    // Conflict on the same index, then refetch of the evicted line.
    miss_fill(32'hBFC0_0408, 32'h2000_0000, 0, -1, 6, "conflict");
    tick();
    miss_fill(32'hBFC0_000C, 32'h1000_0000, 0, -1, 6, "refetch");
    tick();

    // Three wait cycles per beat.
    miss_fill(32'hBFC0_0024, 32'h3000_0000, 3, -1, 18, "waits");
    tick();

    // Flush during the second fill beat: line not validated, refilled immediately.
    miss_fill(32'hBFC0_0010, 32'h4000_0000, 0, 2, 12, "flush_fill");
    tick();
    miss_fill(32'hBFC0_0020, 32'h3000_0000, 0, -1, 6, "post_flush");
    tick();

    // Flush in idle: same-cycle lookup still hits, next cycle misses.
    drive(32'hBFC0_0020, 1'b1);
    chk("idle_flush_hit", {31'b0, Stall_2IF}, 32'd0);
    chk("idle_flush_instr", Instr_2IF, 32'h3000_0000);
    tick();
    drive(32'hBFC0_0020, 1'b0);
    chk("idle_flush_miss", {31'b0, Stall_2IF}, 32'd1);
    miss_fill(32'hBFC0_0020, 32'h3000_0000, 0, -1, 6, "idle_flush_refill");
    tick();

    // Reset asserted mid-fill.
    dbase_cfg = 32'h5000_0000;
    waits_cfg = 0;
    wait_cnt  = 0;
    drive(32'hBFC0_0030, 1'b0);
    chk("rmid_miss", {31'b0, Stall_2IF}, 32'd1);
    tick();
    drive(32'hBFC0_0030, 1'b0);
    chk("rmid_req", {31'b0, Mem_Req}, 32'd1);
    chk("rmid_addr0", Mem_Addr, 32'hBFC0_0030);
    tick();
    drive(32'hBFC0_0030, 1'b0);
    chk("rmid_addr1", Mem_Addr, 32'hBFC0_0034);
    RESET = 1'b0;
    #1;
    chk("rmid_req_drop", {31'b0, Mem_Req}, 32'd0);
    chk("rmid_stall", {31'b0, Stall_2IF}, 32'd1);
    chk("rmid_instr", Instr_2IF, 32'd0);
    Mem_Ack = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    miss_fill(32'hBFC0_0030, 32'h5000_0000, 0, -1, 6, "rmid_restart");
    tick();
    miss_fill(32'hBFC0_0000, 32'h1000_0000, 0, -1, 6, "rmid_old_line");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
